// File: rtl/kbd_input_ctrl_if.sv
// Bundle of keystroke-source handshake and CPU register-bus signals.
// The master side is the source/CPU; the slave side is the controller.
interface kbd_input_ctrl_if #(
  parameter int unsigned DW = 64
);
  logic          key_valid;
  logic [DW-1:0] key_data;
  logic          key_ready;
  logic          cpu_re;
  logic          cpu_we;
  logic [1:0]    cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          irq;

  modport master (
    output key_valid, key_data, cpu_re, cpu_we, cpu_addr, cpu_wdata,
    input  key_ready, cpu_rdata, cpu_rvalid, irq
  );

  modport slave (
    input  key_valid, key_data, cpu_re, cpu_we, cpu_addr, cpu_wdata,
    output key_ready, cpu_rdata, cpu_rvalid, irq
  );
endinterface

// File: rtl/kbd_input_ctrl.sv
// Keyboard input controller: keystroke FIFO with flow control toward the source,
// a STATUS/DATA/CTRL register window for the CPU and a level interrupt.
module kbd_input_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 64
) (
  input logic             clk,
  input logic             reset,
  kbd_input_ctrl_if.slave kbd_if
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  localparam logic [1:0] AddrStatus = 2'd0;
  localparam logic [1:0] AddrData   = 2'd1;
  localparam logic [1:0] AddrCtrl   = 2'd2;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          irq_en_q, irq_en_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;

  logic          full, empty, ctrl_wr, flush, push, pop, rd_access;
  logic [DW-1:0] status;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign ctrl_wr   = kbd_if.cpu_we && (kbd_if.cpu_addr == AddrCtrl);
  assign flush     = ctrl_wr && kbd_if.cpu_wdata[2];
  // A concurrent write wins over a read strobe.
  assign rd_access = kbd_if.cpu_re && !kbd_if.cpu_we;
  assign push      = kbd_if.key_valid && !full && !flush;
  assign pop       = rd_access && (kbd_if.cpu_addr == AddrData) && !empty;

  always_comb begin
    status       = '0;
    status[0]    = !empty;
    status[1]    = full;
    status[2]    = overflow_q;
    status[3]    = irq_en_q;
    status[15:8] = 8'(count_q);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    irq_en_d   = irq_en_q;
    rdata_d    = rdata_q;
    rvalid_d   = rd_access;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end

    // Set beats clear; a word discarded by flush does not count as overflow.
    if (ctrl_wr && kbd_if.cpu_wdata[1]) overflow_d = 1'b0;
    if (kbd_if.key_valid && full && !flush) overflow_d = 1'b1;
    if (ctrl_wr) irq_en_d = kbd_if.cpu_wdata[0];

    if (rd_access) begin
      case (kbd_if.cpu_addr)
        AddrStatus: rdata_d = status;
        AddrData:   rdata_d = empty ? '0 : mem_q[rd_ptr_q];
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= kbd_if.key_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_en_q   <= irq_en_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign kbd_if.key_ready  = !full;
  assign kbd_if.cpu_rdata  = rdata_q;
  assign kbd_if.cpu_rvalid = rvalid_q;
  assign kbd_if.irq        = irq_en_q && !empty;
endmodule

// File: tb/tb_kbd_input_ctrl.sv
// Directed bench for kbd_input_ctrl (DEPTH=8, DW=64); inputs change and
// outputs are sampled on the falling edge.
module tb_kbd_input_ctrl;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  kbd_input_ctrl_if #(.DW(64)) kbd_if ();

  kbd_input_ctrl #(.DEPTH(8), .DW(64)) dut (
    .clk    (clk),
    .reset  (reset),
    .kbd_if (kbd_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_burst(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      kbd_if.key_valid = 1'b1;
      kbd_if.key_data  = base + 64'(i);
    end
    @(negedge clk);
    kbd_if.key_valid = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [63:0] d, output logic v);
    @(negedge clk);
    kbd_if.cpu_re   = 1'b1;
    kbd_if.cpu_addr = a;
    @(negedge clk);
    kbd_if.cpu_re = 1'b0;
    d = kbd_if.cpu_rdata;
    v = kbd_if.cpu_rvalid;
  endtask

  task automatic ctrl_write(input logic [63:0] w);
    @(negedge clk);
    kbd_if.cpu_we    = 1'b1;
    kbd_if.cpu_addr  = 2'd2;
    kbd_if.cpu_wdata = w;
    @(negedge clk);
    kbd_if.cpu_we = 1'b0;
  endtask

  initial begin
    logic [63:0] d;
    logic        v;
    n_tests = 0;
    n_fail  = 0;
    kbd_if.key_valid = 1'b0;
    kbd_if.key_data  = '0;
    kbd_if.cpu_re    = 1'b0;
    kbd_if.cpu_we    = 1'b0;
    kbd_if.cpu_addr  = '0;
    kbd_if.cpu_wdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_key_ready", 64'(kbd_if.key_ready), 64'd1);
    check("rst_irq", 64'(kbd_if.irq), 64'd0);
    check("rst_rvalid", 64'(kbd_if.cpu_rvalid), 64'd0);
    cpu_read(2'd0, d, v);
    check("rst_status", d, 64'h0);

    // Three consecutive pushes, then drain in order
    push_burst(3, 64'h41);
    cpu_read(2'd0, d, v);
    check("status_3", d, 64'h301);
    for (int i = 0; i < 3; i++) begin
      cpu_read(2'd1, d, v);
      check("data_3", d, 64'h41 + 64'(i));
      check("data_3_rvalid", 64'(v), 64'd1);
    end
    @(negedge clk);
    check("rvalid_pulse", 64'(kbd_if.cpu_rvalid), 64'd0);
    check("rdata_hold", kbd_if.cpu_rdata, 64'h43);
    cpu_read(2'd0, d, v);
    check("status_drained", d, 64'h0);

    // Fill, overflow, clear, and pointer wrap (rd/wr start at index 3)
    push_burst(8, 64'h10);
    check("full_key_ready", 64'(kbd_if.key_ready), 64'd0);
    push_burst(1, 64'h99);
    cpu_read(2'd0, d, v);
    check("status_ovf", d, 64'h807);
    ctrl_write(64'h2);
    cpu_read(2'd0, d, v);
    check("status_ovf_clr", d, 64'h803);
    // Overflow set and clear on the same edge: set wins
    @(negedge clk);
    kbd_if.key_valid = 1'b1;
    kbd_if.key_data  = 64'h99;
    kbd_if.cpu_we    = 1'b1;
    kbd_if.cpu_addr  = 2'd2;
    kbd_if.cpu_wdata = 64'h2;
    @(negedge clk);
    kbd_if.key_valid = 1'b0;
    kbd_if.cpu_we    = 1'b0;
    cpu_read(2'd0, d, v);
    check("status_set_wins", d, 64'h807);
    ctrl_write(64'h2);
    for (int i = 0; i < 8; i++) begin
      cpu_read(2'd1, d, v);
      check("data_full", d, 64'h10 + 64'(i));
    end
    cpu_read(2'd0, d, v);
    check("status_after_full", d, 64'h0);

    // Simultaneous push and pop at count 2
    push_burst(2, 64'h20);
    @(negedge clk);
    kbd_if.key_valid = 1'b1;
    kbd_if.key_data  = 64'h55;
    kbd_if.cpu_re    = 1'b1;
    kbd_if.cpu_addr  = 2'd1;
    @(negedge clk);
    kbd_if.key_valid = 1'b0;
    kbd_if.cpu_re    = 1'b0;
    check("pushpop_data", kbd_if.cpu_rdata, 64'h20);
    cpu_read(2'd0, d, v);
    check("pushpop_status", d, 64'h201);
    cpu_read(2'd1, d, v);
    check("pushpop_rd1", d, 64'h21);
    cpu_read(2'd1, d, v);
    check("pushpop_rd2", d, 64'h55);

    // Interrupt enable, empty read, reserved read, read+write collision
    ctrl_write(64'h1);
    check("irq_empty", 64'(kbd_if.irq), 64'd0);
    push_burst(1, 64'hAB);
    check("irq_set", 64'(kbd_if.irq), 64'd1);
    cpu_read(2'd1, d, v);
    check("irq_pop_data", d, 64'hAB);
    check("irq_clr", 64'(kbd_if.irq), 64'd0);
    cpu_read(2'd1, d, v);
    check("empty_read", d, 64'h0);
    check("empty_read_rvalid", 64'(v), 64'd1);
    cpu_read(2'd0, d, v);
    check("status_irq_en", d, 64'h8);
    cpu_read(2'd3, d, v);
    check("reserved_read", d, 64'h0);
    check("reserved_rvalid", 64'(v), 64'd1);
    @(negedge clk);
    kbd_if.cpu_re    = 1'b1;
    kbd_if.cpu_we    = 1'b1;
    kbd_if.cpu_addr  = 2'd2;
    kbd_if.cpu_wdata = 64'h0;
    @(negedge clk);
    kbd_if.cpu_re = 1'b0;
    kbd_if.cpu_we = 1'b0;
    check("rw_collide_rvalid", 64'(kbd_if.cpu_rvalid), 64'd0);
    cpu_read(2'd0, d, v);
    check("rw_collide_status", d, 64'h0);

    // Asynchronous reset mid-stream with count 5, overflow set, irq asserted
    push_burst(8, 64'h30);
    push_burst(1, 64'h99);
    for (int i = 0; i < 3; i++) cpu_read(2'd1, d, v);
    ctrl_write(64'h1);
    check("pre_rst_irq", 64'(kbd_if.irq), 64'd1);
    @(negedge clk);
    kbd_if.cpu_re    = 1'b1;
    kbd_if.cpu_addr  = 2'd1;
    kbd_if.key_valid = 1'b1;
    kbd_if.key_data  = 64'hEE;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_rvalid", 64'(kbd_if.cpu_rvalid), 64'd0);
    check("arst_rdata", kbd_if.cpu_rdata, 64'h0);
    check("arst_key_ready", 64'(kbd_if.key_ready), 64'd1);
    check("arst_irq", 64'(kbd_if.irq), 64'd0);
    @(negedge clk);
    kbd_if.cpu_re    = 1'b0;
    kbd_if.key_valid = 1'b0;
    reset = 1'b0;
    cpu_read(2'd0, d, v);
    check("arst_status", d, 64'h0);

    // Flush with concurrent push: flush wins
    push_burst(2, 64'h60);
    @(negedge clk);
    kbd_if.key_valid = 1'b1;
    kbd_if.key_data  = 64'h77;
    kbd_if.cpu_we    = 1'b1;
    kbd_if.cpu_addr  = 2'd2;
    kbd_if.cpu_wdata = 64'h4;
    @(negedge clk);
    kbd_if.key_valid = 1'b0;
    kbd_if.cpu_we    = 1'b0;
    cpu_read(2'd0, d, v);
    check("flush_status", d, 64'h0);
    cpu_read(2'd1, d, v);
    check("flush_empty_read", d, 64'h0);
    push_burst(1, 64'h88);
    cpu_read(2'd1, d, v);
    check("post_flush_data", d, 64'h88);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/kbd_input_ctrl.md
Name: kbd_input_ctrl

Overview:
Keyboard input controller between the external keystroke source and the processor. Buffers incoming 64-bit keystroke words in a FIFO and presents them to the CPU through a small memory-mapped register interface. Provides a flow-control handshake toward the source and a level interrupt toward the core. Replaces fixed-interval keystroke pacing, so the source never outruns the CPU.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..128
DW, 64, keystroke word width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
key_valid  input  1  source presents key_data this cycle
key_data  input  DW  keystroke word
key_ready  output  1  FIFO can accept a word (= !full)
cpu_re  input  1  CPU read strobe, one cycle per access
cpu_we  input  1  CPU write strobe, one cycle per access
cpu_addr  input  2  0=STATUS, 1=DATA, 2=CTRL, 3=reserved
cpu_wdata  input  DW  CPU write data (CTRL only)
cpu_rdata  output  DW  registered read data
cpu_rvalid  output  1  cpu_rdata valid, one-cycle pulse
irq  output  1  level interrupt = irq_en & !empty

Behaviour:
- Reset (async, any time, including mid-transfer): wr_ptr=rd_ptr=0, count=0, overflow=0, irq_en=0, cpu_rdata=0, cpu_rvalid=0; key_ready=1, irq=0. FIFO contents need not be cleared.
- Push: key_valid & key_ready at an edge writes key_data at wr_ptr, and wr_ptr wraps modulo DEPTH.
- key_ready is derived from registered count only. A same-cycle pop does not make a full FIFO accept.
- Overflow: key_valid while full drops the word and sets sticky overflow. Nothing else changes.
- STATUS read (addr 0): bit0=!empty, bit1=full, bit2=overflow, bit3=irq_en, bits[15:8]=count (zero-extended), all other bits 0. No side effects.
- DATA read (addr 1), FIFO non-empty: cpu_rdata = entry at rd_ptr, then rd_ptr advances (pop). Empty: cpu_rdata=0, no state change, no error flag.
- Read latency: cpu_rdata and cpu_rvalid are registered one cycle after the cpu_re edge. cpu_rvalid stays high exactly one cycle per cpu_re. cpu_rdata holds its value until the next read.
- Reads of CTRL or reserved addresses return 0 with cpu_rvalid=1.
- CTRL write (addr 2):
  - bit0 sets irq_en.
  - bit1=1 clears overflow.
  - bit2=1 flushes: pointers and count go to 0.
  - Bits are applied in the same edge.
- Writes to other addresses are ignored.
- cpu_re & cpu_we together: the write is performed, the read is ignored, and cpu_rvalid=0 next cycle.
- Simultaneous push and pop (not full, not empty): both take effect and count is unchanged.
- Flush and push in the same edge: flush wins, the pushed word is discarded, and overflow is unaffected.
- Overflow set (full push) and clear (CTRL bit1) in the same edge: set wins, overflow=1.
- count is an internal clog2(DEPTH)+1-bit register, range 0..DEPTH.
  - full = (count==DEPTH).
  - empty = (count==0).
- irq is combinational from registered state and carries no extra latency.

Test Plan:
- Reset, then hold: key_ready=1, irq=0, cpu_rvalid=0; STATUS read returns 0x0.
- Push 0x41, 0x42, 0x43 on consecutive cycles; STATUS read returns 0x301. Three DATA reads return 0x41, 0x42, 0x43 in order, each with cpu_rvalid one cycle later. A final STATUS read returns 0x0.
- DEPTH=8: push 8 words and key_ready drops. A 9th push with value 0x99 is dropped and STATUS returns 0x807. CTRL write 0x2 gives STATUS 0x803. DATA reads never return 0x99.
- Fill to count 2, then push 0x55 and pop in the same cycle. The count stays 2 and later reads return the remaining words followed by 0x55. Push/pop across index DEPTH-1 to 0 wraps pointers correctly.
- CTRL write 0x1 with FIFO empty keeps irq=0; push one word and irq=1 after that edge; pop it and irq=0. DATA read while empty returns 0.
- Assert reset asynchronously mid-stream with count 5 and overflow=1. Outputs clear immediately and STATUS returns 0x0 after release. A CTRL flush (0x4) with a concurrent push leaves count 0.
